// File: rtl/cartoon_pkg.sv
// Shared definitions for the cartoonifier pixel pipeline stages.
package cartoon_pkg;

    localparam int unsigned DEFAULT_COORD_BITS = 10;
    localparam int unsigned DEFAULT_ADDR_BITS  = 18;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/axis_counter.sv
// Terminal-count counter for one raster axis; wraps to zero after the terminal value.
module axis_counter #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    assign at_terminal = (count == terminal);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_terminal ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/raster_scanner.sv
// Raster-order pixel stream generator: emits (x, y, addr) per accepted beat for one frame.
module raster_scanner
    import cartoon_pkg::*;
#(
    parameter int unsigned COORD_BITS = DEFAULT_COORD_BITS,
    parameter int unsigned ADDR_BITS  = DEFAULT_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [COORD_BITS-1:0] width,
    input  logic [COORD_BITS-1:0] height,
    input  logic [ADDR_BITS-1:0]  base_addr,
    input  logic                  ready,
    output logic                  valid,
    output logic [COORD_BITS-1:0] x,
    output logic [COORD_BITS-1:0] y,
    output logic [ADDR_BITS-1:0]  addr,
    output logic                  last_col,
    output logic                  last_row,
    output logic                  busy,
    output logic                  frame_done
);

    scan_state_t           state;
    logic [COORD_BITS-1:0] width_q;
    logic [COORD_BITS-1:0] height_q;
    logic [COORD_BITS-1:0] col_terminal;
    logic [COORD_BITS-1:0] row_terminal;
    logic                  accept_start;
    logic                  xfer;
    logic                  col_term;
    logic                  row_term;

    assign accept_start = (state == IDLE) && start && (width != '0) && (height != '0);
    assign xfer         = valid && ready;
    assign col_terminal = width_q - 1'b1;
    assign row_terminal = height_q - 1'b1;
    assign last_col     = valid && col_term;
    assign last_row     = valid && row_term;

    axis_counter #(.WIDTH(COORD_BITS)) u_col (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (accept_start),
        .enable      (xfer),
        .terminal    (col_terminal),
        .count       (x),
        .at_terminal (col_term)
    );

    // Row advances only on the transfer that completes a row.
    axis_counter #(.WIDTH(COORD_BITS)) u_row (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (accept_start),
        .enable      (xfer && col_term),
        .terminal    (row_terminal),
        .count       (y),
        .at_terminal (row_term)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            valid      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            addr       <= '0;
            width_q    <= '0;
            height_q   <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (width != '0 && height != '0) begin
                            width_q  <= width;
                            height_q <= height;
                            addr     <= base_addr;
                            valid    <= 1'b1;
                            state    <= SCAN;
                        end else begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                SCAN: begin
                    if (ready) begin
                        addr <= addr + 1'b1;
                        if (col_term && row_term) begin
                            valid      <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raster_scanner.sv
// Bench for raster_scanner: beat-index reference model plus directed and random frames.
module tb_raster_scanner;

    localparam int CB = 10;
    localparam int AB = 18;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [CB-1:0] width = '0;
    logic [CB-1:0] height = '0;
    logic [AB-1:0] base_addr = '0;
    logic          valid, last_col, last_row, busy, frame_done;
    logic [CB-1:0] x, y;
    logic [AB-1:0] addr;

    raster_scanner #(.COORD_BITS(CB), .ADDR_BITS(AB)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .width      (width),
        .height     (height),
        .base_addr  (base_addr),
        .ready      (ready),
        .valid      (valid),
        .x          (x),
        .y          (y),
        .addr       (addr),
        .last_col   (last_col),
        .last_row   (last_row),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a frame is just a beat index n; position and address follow arithmetically.
    typedef enum {M_IDLE, M_SCAN, M_DONE} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      m_n = 0, m_w = 0, m_h = 0, m_base = 0;
    bit      m_fresh = 1'b1;

    always @(posedge clk) begin
        if (!n_rst) begin
            m_phase = M_IDLE;
            m_n     = 0;
            m_fresh = 1'b1;
        end else begin
            case (m_phase)
                M_IDLE: if (start) begin
                    m_fresh = 1'b0;
                    if (width != 0 && height != 0) begin
                        m_w = width; m_h = height; m_base = base_addr; m_n = 0;
                        m_phase = M_SCAN;
                    end else begin
                        m_phase = M_DONE;
                    end
                end
                M_SCAN: if (ready) begin
                    m_n++;
                    if (m_n == m_w * m_h) m_phase = M_DONE;
                end
                M_DONE: m_phase = M_IDLE;
            endcase
        end
    end

    int          beats = 0, done_cnt = 0, cyc_cnt = 0;
    int          last_xfer_cyc = 0, done_cyc = 0;
    logic [AB-1:0] cap[$];

    always @(negedge clk) begin
        bit exp_valid;
        cyc_cnt++;
        exp_valid = (m_phase == M_SCAN);
        check("valid", valid, exp_valid);
        check("busy", busy, m_phase != M_IDLE);
        check("frame_done", frame_done, m_phase == M_DONE);
        check("last_col", last_col, exp_valid ? (m_n % m_w == m_w - 1) : 0);
        check("last_row", last_row, exp_valid ? (m_n / m_w == m_h - 1) : 0);
        if (exp_valid) begin
            check("x", x, m_n % m_w);
            check("y", y, m_n / m_w);
            check("addr", addr, (m_base + m_n) % (1 << AB));
        end else if (m_fresh) begin
            check("x_reset", x, 0);
            check("y_reset", y, 0);
            check("addr_reset", addr, 0);
        end
        if (valid === 1'b1 && ready === 1'b1) begin
            beats++;
            cap.push_back(addr);
            last_xfer_cyc = cyc_cnt;
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_cnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ready(input int mode, input int cyc);
        case (mode)
            0: ready = 1'b1;
            1: ready = (cyc % 2 == 0);
            default: ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_frame(input int w, input int h, input int b, input int mode,
                             output int nbeats);
        int d0, b0, cyc;
        d0 = done_cnt; b0 = beats; cyc = 0;
        tick();
        start = 1'b1; width = CB'(w); height = CB'(h); base_addr = AB'(b);
        drive_ready(mode, cyc);
        tick();
        start = 1'b0;
        width = CB'($urandom_range(0, 1023));
        height = CB'($urandom_range(0, 1023));
        base_addr = AB'($urandom_range(0, 262143));
        while (done_cnt == d0 && cyc < 2000) begin
            cyc++;
            drive_ready(mode, cyc);
            if (mode == 2) start = (m_phase == M_SCAN) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        start = 1'b0;
        if (done_cnt == d0) begin
            compared++; mismatched++;
            $display("FAIL frame_timeout: got no frame_done expected one w=%0d h=%0d", w, h);
        end
        nbeats = beats - b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, d0, b0, cyc, w, h;
        repeat (3) tick();
        n_rst = 1'b1;
        tick();

        // 4x3 with ready high
        cap.delete();
        run_frame(4, 3, 'h100, 0, nb);
        check("f1_beats", nb, 12);
        check("f1_first_addr", cap[0], 'h100);
        check("f1_last_addr", cap[11], 'h10B);
        check("f1_done_latency", done_cyc - last_xfer_cyc, 1);

        // 4x3 with ready toggling
        run_frame(4, 3, 'h100, 1, nb);
        check("f2_beats", nb, 12);
        check("f2_done_latency", done_cyc - last_xfer_cyc, 1);

        // address wrap
        cap.delete();
        run_frame(2, 2, 'h3FFFE, 0, nb);
        check("wrap_beats", nb, 4);
        check("wrap_a0", cap[0], 'h3FFFE);
        check("wrap_a1", cap[1], 'h3FFFF);
        check("wrap_a2", cap[2], 'h00000);
        check("wrap_a3", cap[3], 'h00001);

        // zero width
        run_frame(0, 5, 'h10, 0, nb);
        check("zero_beats", nb, 0);

        // mid-frame start ignored, then reset at beat 5
        d0 = done_cnt; b0 = beats; cyc = 0;
        tick();
        start = 1'b1; width = 4; height = 3; base_addr = 'h20; ready = 1'b1;
        tick();
        start = 1'b0;
        while (beats - b0 < 5 && cyc < 100) begin
            start = (beats - b0 == 2);
            width = 2; height = 2;
            tick();
            cyc++;
        end
        start = 1'b0;
        check("rst_beats_before", beats - b0, 5);
        n_rst = 1'b0;
        tick();
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        n_rst = 1'b1;
        repeat (4) tick();
        check("rst_no_done", done_cnt - d0, 0);

        // 1x1 with back-to-back start
        d0 = done_cnt; cyc = 0;
        start = 1'b1; width = 1; height = 1; base_addr = 'h55; ready = 1'b1;
        tick();
        check("b2b_valid", valid, 1);
        check("b2b_last_col", last_col, 1);
        check("b2b_last_row", last_row, 1);
        tick();
        check("b2b_done", frame_done, 1);
        tick();
        check("b2b_idle_busy", busy, 0);
        tick();
        check("b2b_second_valid", valid, 1);
        start = 1'b0;
        while (done_cnt - d0 < 2 && cyc < 20) begin tick(); cyc++; end
        check("b2b_frames", done_cnt - d0, 2);

        // random frames with random ready and stray starts
        repeat (10) begin
            w = $urandom_range(0, 6);
            h = $urandom_range(1, 5);
            run_frame(w, h, $urandom_range(0, 262143), 2, nb);
            check("rand_beats", nb, w * h);
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
